// File: rtl/frame_parser_stream_if.sv
// frame_parser_stream_if: FIFO read port plus header, data and status ready/valid channels
interface frame_parser_stream_if;
  logic [7:0] rx_fifo_data;
  logic rx_fifo_empty;
  logic rx_fifo_rd_en;
  logic hdr_valid;
  logic hdr_ready;
  logic [7:0] hdr_cmd;
  logic [31:0] hdr_addr;
  logic data_valid;
  logic data_ready;
  logic [7:0] data_byte;
  logic data_last;
  logic status_valid;
  logic status_ready;
  logic [7:0] status_code;
  logic parser_busy;
  modport master (
    input rx_fifo_data, rx_fifo_empty, hdr_ready, data_ready, status_ready,
    output rx_fifo_rd_en, hdr_valid, hdr_cmd, hdr_addr, data_valid, data_byte, data_last,
    output status_valid, status_code, parser_busy
  );
  modport slave (
    output rx_fifo_data, rx_fifo_empty, hdr_ready, data_ready, status_ready,
    input rx_fifo_rd_en, hdr_valid, hdr_cmd, hdr_addr, data_valid, data_byte, data_last,
    input status_valid, status_code, parser_busy
  );
endinterface

// File: rtl/frame_parser_stream.sv
// frame_parser_stream: streaming host-frame parser with inline CRC-8 and header/data/status channels
module frame_parser_stream #(
  parameter int unsigned CLK_FREQ_HZ = 125_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned TIMEOUT_BYTE_TIMES = 10,
  parameter int unsigned ADDR_BYTES = 4,
  parameter int unsigned MAX_BEATS = 16,
  parameter logic [7:0] SOF = 8'hA5,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input logic clk,
  input logic rst,
  frame_parser_stream_if.master bus
);
  localparam int unsigned TIMEOUT_CLOCKS = CLK_FREQ_HZ / (BAUD_RATE / 10) * TIMEOUT_BYTE_TIMES;
  localparam int unsigned TW = $clog2(TIMEOUT_CLOCKS + 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, HDR, DATA, CRC, STATUS} state_t;
  state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d, crc_q, crc_d, code_q, code_d, din, crc_nx;
  logic [31:0] addr_q, addr_d;
  logic [1:0] idx_q, idx_d;
  logic [6:0] cnt_q, cnt_d, n_bytes;
  logic [TW-1:0] to_q, to_d;
  logic empty, pop, counting, to_hit, bad_size, bad_len, last;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ CRC_POLY : {r[6:0], 1'b0};
    return r;
  endfunction

  assign din = bus.rx_fifo_data;
  assign empty = bus.rx_fifo_empty;
  assign pop = bus.rx_fifo_rd_en;
  assign n_bytes = ({3'b0, cmd_q[3:0]} + 7'd1) << cmd_q[5:4];
  assign last = cnt_q + 7'd1 == n_bytes;
  assign bad_size = din[5:4] == 2'b11;
  assign bad_len = 32'(din[3:0]) >= MAX_BEATS;
  assign counting = empty && (state_q inside {CMD, ADDR, DATA, CRC});
  assign to_hit = counting && to_q == TW'(TIMEOUT_CLOCKS);
  assign crc_nx = crc8(crc_q, din);

  assign bus.rx_fifo_rd_en = !empty && (state_q inside {IDLE, CMD, ADDR, CRC} || (state_q == DATA && bus.data_ready));
  assign bus.data_valid = state_q == DATA && !empty;
  assign bus.data_byte = din;
  assign bus.data_last = state_q == DATA && !empty && last;
  assign bus.hdr_valid = state_q == HDR;
  assign bus.hdr_cmd = cmd_q;
  assign bus.hdr_addr = addr_q;
  assign bus.status_valid = state_q == STATUS;
  assign bus.status_code = code_q;
  assign bus.parser_busy = state_q != IDLE;

  // Next-state: one byte consumed per cycle, timeout overrides any waiting byte state
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    crc_d = crc_q;
    code_d = code_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    to_d = (counting && !to_hit) ? to_q + 1'b1 : '0;
    if (to_hit) begin
      state_d = STATUS;
      code_d = 8'h04;
    end else begin
      case (state_q)
        IDLE: if (pop && din == SOF) begin
          state_d = CMD;
          crc_d = '0;
        end
        CMD: if (pop) begin
          cmd_d = din;
          crc_d = crc_nx;
          addr_d = '0;
          idx_d = '0;
          state_d = (bad_size || bad_len) ? STATUS : ADDR;
          code_d = bad_size ? 8'h02 : 8'h07;
        end
        ADDR: if (pop) begin
          addr_d[{idx_q, 3'b000} +: 8] = din;
          crc_d = crc_nx;
          idx_d = idx_q + 2'd1;
          state_d = 32'(idx_q) == ADDR_BYTES - 1 ? HDR : ADDR;
        end
        HDR: begin
          cnt_d = '0;
          state_d = bus.hdr_ready ? (cmd_q[7] ? CRC : DATA) : HDR;
        end
        DATA: if (pop) begin
          crc_d = crc_nx;
          cnt_d = cnt_q + 7'd1;
          state_d = last ? CRC : DATA;
        end
        CRC: if (pop) begin
          code_d = din == crc_q ? 8'h00 : 8'h01;
          state_d = STATUS;
        end
        STATUS: state_d = bus.status_ready ? IDLE : STATUS;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and frame registers, all cleared by reset so an aborted frame leaves no trace
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q <= '0;
      addr_q <= '0;
      crc_q <= '0;
      code_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      crc_q <= crc_d;
      code_q <= code_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  end
endmodule
